// File: rtl/bsk_pkg.sv
// Shared constants for the BSK receiver command path: clock, sampling and
// debounce-filter defaults, plus derived divider and counter widths.
package bsk_pkg;

  localparam int CLOCK_IN    = 2_000_000;
  localparam int SAMPLE_FREQ = 100_000;
  localparam int FILTER_LEN  = 8;
  localparam int SAMPLE_DIV  = CLOCK_IN / SAMPLE_FREQ;
  localparam int CNT_W       = $clog2(FILTER_LEN + 1);

  function automatic int cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/com_filter_channel.sv
// One command line: 2-flop synchroniser, saturating up/down integrator and
// hysteresis output bit. blk is active-low and overrides the tick.
module com_filter_channel
  import bsk_pkg::*;
#(
  parameter int FILTER_LEN = bsk_pkg::FILTER_LEN
) (
  input  logic clk,
  input  logic aclr,
  input  logic tick,
  input  logic blk,
  input  logic raw,
  output logic out
);

  localparam int CW = cnt_width(FILTER_LEN);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          s;

  // raw is active-low, so a low line integrates upwards
  assign s = ~sync[1];

  always_comb begin
    cnt_nxt = cnt;
    if (s && (cnt < CW'(FILTER_LEN)))
      cnt_nxt = cnt + CW'(1);
    else if (!s && (cnt != '0))
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sync <= 2'b11;
      cnt  <= '0;
      out  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (!blk) begin
        cnt <= '0;
        out <= 1'b0;
      end else if (tick) begin
        cnt <= cnt_nxt;
        if (cnt_nxt == CW'(FILTER_LEN))
          out <= 1'b1;
        else if (cnt_nxt == '0)
          out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/com_input_filter.sv
// Command input conditioning: sample-rate prescaler, per-channel debounce
// filters and a one-clock change strobe for event logging.
module com_input_filter
  import bsk_pkg::*;
#(
  parameter int CHANNELS    = 16,
  parameter int CLOCK_IN    = bsk_pkg::CLOCK_IN,
  parameter int SAMPLE_FREQ = bsk_pkg::SAMPLE_FREQ,
  parameter int FILTER_LEN  = bsk_pkg::FILTER_LEN
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic [CHANNELS-1:0] iRaw,
  input  logic                iBl,
  output logic [CHANNELS-1:0] oCom,
  output logic                oChange
);

  localparam int SAMPLE_DIV = CLOCK_IN / SAMPLE_FREQ;
  localparam int PW         = $clog2(SAMPLE_DIV);

  if (SAMPLE_DIV < 2) begin : g_bad_div
    $error("com_input_filter: SAMPLE_DIV must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_len
    $error("com_input_filter: FILTER_LEN must be at least 1");
  end

  logic [PW-1:0]       presc;
  logic                tick;
  logic [CHANNELS-1:0] com_prev;

  assign tick = (presc == '0);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      presc <= PW'(SAMPLE_DIV - 1);
    else if (tick)
      presc <= PW'(SAMPLE_DIV - 1);
    else
      presc <= presc - PW'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    com_filter_channel #(
      .FILTER_LEN(FILTER_LEN)
    ) u_ch (
      .clk (clk),
      .aclr(aclr),
      .tick(tick),
      .blk (iBl),
      .raw (iRaw[i]),
      .out (oCom[i])
    );
  end

  // Strobe trails the oCom update by one clock; any number of bits changing
  // together yields a single pulse.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      com_prev <= '0;
      oChange  <= 1'b0;
    end else begin
      com_prev <= oCom;
      oChange  <= |(oCom ^ com_prev);
    end
  end

endmodule
